uart_tx: RTL

Serial UART transmitter, 8-N-1 framing by default. It sits alongside the UART receiver and drives the `tx_uart` line. It accepts one byte per valid/ready handshake and serialises it LSB-first at a baud rate fixed by parameters. The default timing targets the 50 MHz board clock (20 ns period) and 115200 baud.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_if.sv | 31 +++
 rtl/uart_baud_cnt.sv | 34 +++
 rtl/uart_tx.sv | 125 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg : framing constants and FSM state type shared by UART TX and RX  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package uart_pkg;

   localparam int unsigned C_CLK_FREQ  = 50_000_000;
   localparam int unsigned C_BAUD      = 115_200;
   localparam int unsigned C_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_if : byte handshake and serial line bundle of the UART TX         |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
interface uart_tx_if;

   logic [7:0] tx_data;
   logic       tx_vld;
   logic       tx_rdy;
   logic       tx_uart;
   logic       tx_busy;

   modport master (
      output tx_data,
      output tx_vld,
      input  tx_rdy,
      input  tx_uart,
      input  tx_busy
   );

   modport slave (
      input  tx_data,
      input  tx_vld,
      output tx_rdy,
      output tx_uart,
      output tx_busy
   );

endinterface
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_baud_cnt : bit-period counter, pulses bit_end on the last cycle of   |
// |                 every BAUD_CNT-cycle bit while enabled                    |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module uart_baud_cnt #(
   parameter int unsigned BAUD_CNT = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic bit_end
);

   localparam int unsigned          C_W    = $clog2(BAUD_CNT);
   localparam logic [C_W-1:0]       C_LAST = C_W'(BAUD_CNT - 1);

   logic [C_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!en || r_cnt == C_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign bit_end = en && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx  : UART transmitter, 8-N-1 (8-E-1 with UART_TX_PARITY_EN),        |
// |            LSB first, one byte per valid/ready handshake                  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = C_CLK_FREQ,
   parameter int unsigned BAUD     = C_BAUD,
   parameter int unsigned BAUD_CNT = CLK_FREQ / BAUD
) (
   input  logic     clk,
   input  logic     rst_n,
   uart_tx_if.slave tx_if
);

   localparam logic [2:0] C_LAST_BIT = 3'(C_DATA_BITS - 1);

   uart_state_e            r_state;
   uart_state_e            w_next_state;
   logic [C_DATA_BITS-1:0] r_shift;
   logic [C_DATA_BITS-1:0] w_shift_next;
   logic [2:0]             r_bit_cnt;
   logic [2:0]             w_bit_cnt_next;
   logic                   r_tx_uart;
   logic                   w_line_next;
   logic                   w_bit_end;
`ifdef UART_TX_PARITY_EN
   logic                   r_parity;
`endif

   uart_baud_cnt #(
      .BAUD_CNT (BAUD_CNT)
   ) u_baud_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (r_state != IDLE),
      .bit_end (w_bit_end)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_tx_uart <= 1'b1;
      end else begin
         r_state   <= w_next_state;
         r_shift   <= w_shift_next;
         r_bit_cnt <= w_bit_cnt_next;
         r_tx_uart <= w_line_next;
      end
   end

`ifdef UART_TX_PARITY_EN
   // Even parity is latched with the byte since the shifter loses the data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_parity <= 1'b0;
      end else if (r_state == IDLE && tx_if.tx_vld) begin
         r_parity <= ^tx_if.tx_data;
      end
   end
`endif

   always_comb begin
      w_next_state   = r_state;
      w_shift_next   = r_shift;
      w_bit_cnt_next = r_bit_cnt;
      w_line_next    = 1'b1;
      case (r_state)
         IDLE: begin
            if (tx_if.tx_vld) begin
               w_next_state = START;
               w_shift_next = tx_if.tx_data;
            end
         end
         START: begin
            if (w_bit_end) w_next_state = DATA;
         end
         DATA: begin
            if (w_bit_end) begin
               w_shift_next = r_shift >> 1;
               if (r_bit_cnt == C_LAST_BIT) begin
                  w_bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                  w_next_state   = PARITY;
`else
                  w_next_state   = STOP;
`endif
               end else begin
                  w_bit_cnt_next = r_bit_cnt + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (w_bit_end) w_next_state = STOP;
         end
`endif
         STOP: begin
            if (w_bit_end) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase

      // Line level is derived from the upcoming state so tx_uart stays a pure register.
      case (w_next_state)
         START:   w_line_next = 1'b0;
         DATA:    w_line_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  w_line_next = r_parity;
`endif
         default: w_line_next = 1'b1;
      endcase
   end

   assign tx_if.tx_uart = r_tx_uart;
   assign tx_if.tx_rdy  = (r_state == IDLE);
   assign tx_if.tx_busy = (r_state != IDLE);

endmodule
`default_nettype wire
